// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add MULT/MULTU sequencer.
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;
endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bundle between the EX stage and the multiplier sequencer.
interface mult_sequencer_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, is_signed, a, b, input busy, done, hi, lo);
  modport slave  (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/ripple_adder.sv
// Carry-in-free ripple-carry adder built from single-bit full adder cells.
module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle MULT/MULTU: magnitudes are multiplied by one shared adder over
// WIDTH cycles, then the sign is applied in a single FIX cycle.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, acc, mq, addend, sum, hi_q, lo_q;
  logic [CNT_W-1:0]   cnt;
  logic               neg, carry, done_q;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Two's-complement magnitude; 0x8000_0000 maps to itself as an unsigned 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign addend   = mq[0] ? mcand : '0;
  assign prod     = {acc, mq};
  assign prod_fix = neg ? (~prod + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (acc),
    .y    (addend),
    .sum  (sum),
    .cout (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mq     <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: if (bus.start) begin
          mcand <= magnitude(bus.a, bus.is_signed);
          mq    <= magnitude(bus.b, bus.is_signed);
          acc   <= '0;
          neg   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          cnt   <= CNT_W'(WIDTH - 1);
        end
        RUN: begin
          // The adder carry becomes the new MSB as {acc,mq} shifts right.
          acc <= {carry, sum[WIDTH-1:1]};
          mq  <= {sum[0], mq[WIDTH-1:1]};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
